// File: rtl/instr_mem_loadable.sv
// Instruction memory with a 1-cycle registered fetch port and a byte-serial loader (IDLE/LOAD).
// Define IMEM_PARITY_EN to store one even-parity bit per word and report read mismatches.
module instr_mem_loadable #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              prog_en,
  input  logic              prog_byte_valid,
  input  logic [7:0]        prog_byte,
  input  logic              prog_inj,
  output logic              busy,
  output logic              prog_done,
  output logic [ADDR_W:0]   prog_count,
  output logic              prog_ovf,
  output logic              parity_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;
  localparam int BC_W  = (NB > 1) ? $clog2(NB) : 1;
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  logic [0:0]        r_state;
  logic [BC_W-1:0]   r_byte_cnt;
  logic [DATA_W-1:0] r_asm;
  logic [ADDR_W:0]   r_count;
  logic              r_ovf;
  logic              r_done;
  logic              r_fetch_valid;
  logic [MEM_W-1:0]  r_rd_word;
  logic [MEM_W-1:0]  r_mem [DEPTH] = '{default: '0};

  logic [DATA_W-1:0] w_word;
  logic [MEM_W-1:0]  w_wr_word;
  logic              w_fetch_acc;
  logic              w_last_byte;
  logic              w_full;
  logic              w_wr_en;

  // LOAD takes priority over a fetch presented on the same edge.
  assign w_fetch_acc = (r_state == ST_IDLE) && fetch_req && !prog_en;
  assign w_last_byte = (r_byte_cnt == BC_W'(NB - 1));
  assign w_full      = (r_count == (ADDR_W + 1)'(DEPTH));
  assign w_wr_en     = !rst && (r_state == ST_LOAD) && prog_en && prog_byte_valid
                       && w_last_byte && !w_full;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign w_word[gi*8 +: 8] = (r_byte_cnt == BC_W'(gi)) ? prog_byte : r_asm[gi*8 +: 8];
    end
  endgenerate

`ifdef IMEM_PARITY_EN
  assign w_wr_word  = {(^w_word) ^ prog_inj, w_word};
  // Stored bit makes the whole word even; an odd total on read is a mismatch.
  assign parity_err = r_fetch_valid & (^r_rd_word);
`else
  logic w_unused_inj;
  assign w_unused_inj = prog_inj;
  assign w_wr_word    = w_word;
  assign parity_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_count[ADDR_W-1:0]] <= w_wr_word;
    end
    if (rst) begin
      r_rd_word <= '0;
    end else if (w_fetch_acc) begin
      r_rd_word <= r_mem[fetch_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_byte_cnt    <= '0;
      r_asm         <= '0;
      r_count       <= '0;
      r_ovf         <= 1'b0;
      r_done        <= 1'b0;
      r_fetch_valid <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_fetch_valid <= w_fetch_acc;
      if (r_state == ST_IDLE) begin
        if (prog_en) begin
          r_state    <= ST_LOAD;
          r_byte_cnt <= '0;
          r_count    <= '0;
          r_ovf      <= 1'b0;
        end
      end else if (!prog_en) begin
        // Exit drops any partial word and ignores a byte on this edge.
        r_state    <= ST_IDLE;
        r_done     <= 1'b1;
        r_byte_cnt <= '0;
      end else if (prog_byte_valid) begin
        r_asm <= w_word;
        if (w_last_byte) begin
          r_byte_cnt <= '0;
          if (w_full) begin
            r_ovf <= 1'b1;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end else begin
          r_byte_cnt <= r_byte_cnt + 1'b1;
        end
      end
    end
  end

  assign fetch_valid = r_fetch_valid;
  assign fetch_data  = r_rd_word[DATA_W-1:0];
  assign busy        = (r_state == ST_LOAD);
  assign prog_done   = r_done;
  assign prog_count  = r_count;
  assign prog_ovf    = r_ovf;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Scoreboard bench for instr_mem_loadable (ADDR_W=2 so overflow is reachable).
module tb_instr_mem_loadable;

  localparam int AW    = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
`ifdef IMEM_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          prog_en;
  logic          prog_byte_valid;
  logic [7:0]    prog_byte;
  logic          prog_inj;
  logic          busy;
  logic          prog_done;
  logic [AW:0]   prog_count;
  logic          prog_ovf;
  logic          parity_err;

  instr_mem_loadable #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .prog_en(prog_en), .prog_byte_valid(prog_byte_valid), .prog_byte(prog_byte),
    .prog_inj(prog_inj), .busy(busy), .prog_done(prog_done),
    .prog_count(prog_count), .prog_ovf(prog_ovf), .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        par;
  } sb_t;

  sb_t         sb_q[$];
  sb_t         mon_e;
  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  logic        rst_seen = 1'b1;
  logic [31:0] last_data = '0;
  logic [31:0] exp_mem [DEPTH];
  logic        exp_inj [DEPTH];
  logic [7:0]  bq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_par(input int a);
    return exp_inj[a] & PAR_ON;
  endfunction

  always @(posedge clk) begin
    cyc++;
    rst_seen = rst;
  end

  // Output monitor: pops an entry when its due cycle arrives, otherwise expects an idle port.
  always @(negedge clk) begin
    if (rst_seen) last_data = '0;
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      mon_e = sb_q.pop_front();
      chk("fetch_valid", {63'd0, fetch_valid}, 64'd1);
      chk("fetch_data", {32'd0, fetch_data}, {32'd0, mon_e.data});
      chk("parity_err", {63'd0, parity_err}, {63'd0, mon_e.par});
      last_data = mon_e.data;
    end else begin
      chk("no_valid", {63'd0, fetch_valid}, 64'd0);
      chk("data_hold", {32'd0, fetch_data}, {32'd0, last_data});
      chk("parity_idle", {63'd0, parity_err}, 64'd0);
    end
  end

  task automatic do_fetch(input int a);
    sb_t e;
    fetch_req  = 1'b1;
    fetch_addr = AW'(a);
    e.cyc  = cyc + 1;
    e.data = exp_mem[a];
    e.par  = exp_par(a);
    sb_q.push_back(e);
    tick();
    fetch_req = 1'b0;
  endtask

  task automatic load(input int inj_word, input logic exit_byte);
    int          cnt;
    int          bc;
    int          widx;
    logic [31:0] asmw;
    logic        ovf;
    cnt = 0; bc = 0; widx = 0; asmw = '0; ovf = 1'b0;
    prog_en = 1'b1;
    tick();
    @(negedge clk);
    chk("busy_load", {63'd0, busy}, 64'd1);
    chk("count_clr", {61'd0, prog_count}, 64'd0);
    chk("ovf_clr", {63'd0, prog_ovf}, 64'd0);
    foreach (bq[i]) begin
      prog_byte_valid = 1'b1;
      prog_byte       = bq[i];
      prog_inj        = (bc == 3 && widx == inj_word);
      asmw[bc*8 +: 8] = bq[i];
      if (bc == 3) begin
        if (cnt < DEPTH) begin
          exp_mem[cnt] = asmw;
          exp_inj[cnt] = prog_inj;
          cnt++;
        end else begin
          ovf = 1'b1;
        end
        widx++;
        bc = 0;
      end else begin
        bc++;
      end
      tick();
    end
    prog_byte_valid = 1'b0;
    prog_inj        = 1'b0;
    prog_en         = 1'b0;
    if (exit_byte) begin
      prog_byte_valid = 1'b1;
      prog_byte       = 8'hEE;
    end
    tick();
    prog_byte_valid = 1'b0;
    @(negedge clk);
    chk("prog_done", {63'd0, prog_done}, 64'd1);
    chk("busy_exit", {63'd0, busy}, 64'd0);
    chk("prog_count", {61'd0, prog_count}, 64'(cnt));
    chk("prog_ovf", {63'd0, prog_ovf}, {63'd0, ovf});
    tick();
    @(negedge clk);
    chk("done_pulse", {63'd0, prog_done}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; prog_en = 1'b0;
    prog_byte_valid = 1'b0; prog_byte = '0; prog_inj = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_mem[i] = '0;
      exp_inj[i] = 1'b0;
    end
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, prog_done}, 64'd0);
    chk("rst_count", {61'd0, prog_count}, 64'd0);
    chk("rst_ovf", {63'd0, prog_ovf}, 64'd0);

    // Fresh memory reads zero.
    do_fetch(0);
    tick();

    // Reset part-way into the second word of a load.
    prog_en = 1'b1;
    tick();
    bq = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h11, 8'h22};
    foreach (bq[i]) begin
      prog_byte_valid = 1'b1;
      prog_byte       = bq[i];
      tick();
    end
    prog_byte_valid = 1'b0;
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_done", {63'd0, prog_done}, 64'd0);
    chk("mid_rst_count", {61'd0, prog_count}, 64'd0);
    rst = 1'b0;
    prog_en = 1'b0;
    tick();
    @(negedge clk);
    chk("mid_rst_nodone1", {63'd0, prog_done}, 64'd0);
    tick();
    @(negedge clk);
    chk("mid_rst_nodone2", {63'd0, prog_done}, 64'd0);
    exp_mem[0] = 32'h00500513;
    do_fetch(0);
    do_fetch(1);
    tick();

    // Two-word program, parity injected on word 0.
    bq = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h01};
    load(0, 1'b0);
    do_fetch(0);
    do_fetch(1);
    do_fetch(2);
    tick();

    // Fetch just before LOAD entry delivers; same-edge fetch and in-LOAD fetch are dropped.
    do_fetch(1);
    prog_en    = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = '0;
    tick();
    @(negedge clk);
    chk("busy_same_edge", {63'd0, busy}, 64'd1);
    tick();
    fetch_req = 1'b0;
    prog_en   = 1'b0;
    tick();
    @(negedge clk);
    chk("done_short", {63'd0, prog_done}, 64'd1);
    chk("count_short", {61'd0, prog_count}, 64'd0);
    tick();

    // Five words into a four-word memory.
    bq.delete();
    for (int w = 0; w < 5; w++)
      for (int k = 0; k < 4; k++)
        bq.push_back(8'((w << 4) | (k * 3) | 8'h80));
    load(2, 1'b0);
    for (int a = 0; a < DEPTH; a++) do_fetch(a);
    tick();

    // Partial word plus a byte on the exit edge: nothing written, flags cleared.
    bq = '{8'hAA, 8'hAA, 8'hAA};
    load(-1, 1'b1);
    do_fetch(0);
    do_fetch(3);

    repeat (3) tick();
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
